// File: rtl/sseg_scan_if.sv
// Bus between user logic and the 7-segment scan controller: value/enable
// loads in, anode/segment drive and status back out.
interface sseg_scan_if;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pend;
  logic        frame_done;

  modport master (
    output din, dp_in, digit_en, load,
    input  an, seg, dp, pend, frame_done
  );

  modport slave (
    input  din, dp_in, digit_en, load,
    output an, seg, dp, pend, frame_done
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with frame-aligned shadow loads.
// Optional: define LEADING_ZERO_BLANK_EN to auto-blank digits above the top non-zero nibble.
module sseg_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int CNT_W = 17
) (
  input  logic         clk,
  input  logic         rst,
  sseg_scan_if.slave   bus
);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             tick;
  logic             fb;

  logic [15:0] sh_val;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_en;
  logic        pend_r;

  logic [15:0] act_val;
  logic [3:0]  act_dp;
  logic [3:0]  act_en;

  logic [3:0]  lz_blank;
  logic [3:0]  nib;
  logic        show;

  logic [3:0]  an_p1;
  logic [6:0]  seg_p1;
  logic        dp_p1;
  logic        fd_p1;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = (cnt == CNT_W'(DIV - 1));
  assign fb   = tick && (idx == 2'd3);

  // Stage p0: prescaler, digit index, shadow and active registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      sh_val  <= '0;
      sh_dp   <= '0;
      sh_en   <= '0;
      pend_r  <= 1'b0;
      act_val <= '0;
      act_dp  <= '0;
      act_en  <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) idx <= idx + 2'd1;
      // A load landing on the frame boundary bypasses the shadow entirely.
      if (bus.load && fb) begin
        act_val <= bus.din;
        act_dp  <= bus.dp_in;
        act_en  <= bus.digit_en;
        pend_r  <= 1'b0;
      end else begin
        if (fb && pend_r) begin
          act_val <= sh_val;
          act_dp  <= sh_dp;
          act_en  <= sh_en;
          pend_r  <= 1'b0;
        end
        if (bus.load) begin
          sh_val <= bus.din;
          sh_dp  <= bus.dp_in;
          sh_en  <= bus.digit_en;
          pend_r <= 1'b1;
        end
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign lz_blank = {act_val[15:12] == 4'h0, act_val[15:8] == 8'h0,
                     act_val[15:4] == 12'h0, 1'b0};
`else
  assign lz_blank = 4'b0000;
`endif

  assign nib  = act_val[4*idx +: 4];
  assign show = act_en[idx] && !lz_blank[idx];

  // Stage p1: registered pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      an_p1  <= 4'hF;
      seg_p1 <= 7'h7F;
      dp_p1  <= 1'b1;
      fd_p1  <= 1'b0;
    end else begin
      an_p1  <= show ? ~(4'b0001 << idx) : 4'hF;
      seg_p1 <= show ? hex7(nib) : 7'h7F;
      dp_p1  <= show ? ~act_dp[idx] : 1'b1;
      fd_p1  <= fb;
    end
  end

  assign bus.an         = an_p1;
  assign bus.seg        = seg_p1;
  assign bus.dp         = dp_p1;
  assign bus.pend       = pend_r;
  assign bus.frame_done = fd_p1;

endmodule
